// File: rtl/ad7606_pkg.sv
// Shared state encoding and default timing constants for the AD7606 sequencer.
package ad7606_pkg;

  typedef enum logic [3:0] {
    OFF,
    PWR_WAIT,
    ADC_RST,
    IDLE,
    CONVST,
    BUSY_HI,
    BUSY_LO,
    RD_LO,
    RD_HI
  } ad7606_state_t;

  localparam int DEF_CLK_FREQUENCY      = 30_000_000;
  localparam int DEF_RESET_TICKS        = 2;
  localparam int DEF_CONVST_LOW_TICKS   = 2;
  localparam int DEF_RD_LOW_TICKS       = 2;
  localparam int DEF_RD_HIGH_TICKS      = 1;
  localparam int DEF_BUSY_TIMEOUT_TICKS = 300;
  localparam int DEF_NUM_CH             = 8;
  localparam int DEF_DATA_W             = 16;

  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/ad7606_tick_timer.sv
// Loadable down-counter shared by every timed state; holds at zero once expired.
// Latency: load takes effect on the next edge; no backpressure.
module ad7606_tick_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic [W-1:0] value,
  output logic         expired
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
    end else if (load) begin
      value <= load_value;
    end else if (value != '0) begin
      value <= value - 1'b1;
    end
  end

  assign expired = (value == '0);

endmodule

// File: rtl/ad7606_conv_ctrl.sv
// AD7606 power-up, conversion and parallel readout sequencer; all outputs registered.
// Latency: CONVST one cycle after an accepted start; no backpressure, start ignored unless ready.
module ad7606_conv_ctrl
  import ad7606_pkg::*;
#(
  parameter int CLK_FREQUENCY      = DEF_CLK_FREQUENCY,
  parameter int POWER_ON_TICKS     = 30 * (CLK_FREQUENCY / 1_000),
  parameter int RESET_TICKS        = DEF_RESET_TICKS,
  parameter int CONVST_LOW_TICKS   = DEF_CONVST_LOW_TICKS,
  parameter int RD_LOW_TICKS       = DEF_RD_LOW_TICKS,
  parameter int RD_HIGH_TICKS      = DEF_RD_HIGH_TICKS,
  parameter int BUSY_TIMEOUT_TICKS = DEF_BUSY_TIMEOUT_TICKS,
  parameter int NUM_CH             = DEF_NUM_CH,
  parameter int DATA_W             = DEF_DATA_W,
  localparam int CH_W              = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              power,
  input  logic              start,
  output logic              ready,
  output logic              adc_reset,
  output logic              adc_convst_n,
  input  logic              adc_busy,
  output logic              adc_cs_n,
  output logic              adc_rd_n,
  input  logic [DATA_W-1:0] adc_db,
  output logic              sample_valid,
  output logic [CH_W-1:0]   sample_ch,
  output logic [DATA_W-1:0] sample_data,
  output logic              frame_done,
  output logic              timeout_err
);

  localparam int TIMER_W = cnt_width(POWER_ON_TICKS + RESET_TICKS + CONVST_LOW_TICKS +
                                     RD_LOW_TICKS + RD_HIGH_TICKS + BUSY_TIMEOUT_TICKS);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  ad7606_state_t      state;
  logic [CH_W-1:0]    ch_cnt;
  logic               busy_meta, busy_s;
  logic               tmr_load;
  logic [TIMER_W-1:0] tmr_load_value;
  logic [TIMER_W-1:0] tmr_value;
  logic               tmr_expired;
  logic               rd_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_meta <= 1'b0;
      busy_s    <= 1'b0;
    end else begin
      busy_meta <= adc_busy;
      busy_s    <= busy_meta;
    end
  end

  ad7606_tick_timer #(.W(TIMER_W)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (tmr_load),
    .load_value (tmr_load_value),
    .value      (tmr_value),
    .expired    (tmr_expired)
  );

  assign rd_last = (tmr_value == '0);

  // Reload the timer on exactly the edge that enters each timed state.
  always_comb begin
    tmr_load       = 1'b0;
    tmr_load_value = '0;
    if (power) begin
      case (state)
        OFF: begin
          tmr_load       = 1'b1;
          tmr_load_value = TIMER_W'(POWER_ON_TICKS);
        end
        PWR_WAIT: if (tmr_expired) begin
          tmr_load       = 1'b1;
          tmr_load_value = TIMER_W'(RESET_TICKS - 1);
        end
        IDLE: if (start) begin
          tmr_load       = 1'b1;
          tmr_load_value = TIMER_W'(CONVST_LOW_TICKS - 1);
        end
        CONVST: if (tmr_expired) begin
          tmr_load       = 1'b1;
          tmr_load_value = TIMER_W'(BUSY_TIMEOUT_TICKS - 1);
        end
        BUSY_HI: if (busy_s) begin
          tmr_load       = 1'b1;
          tmr_load_value = TIMER_W'(BUSY_TIMEOUT_TICKS - 1);
        end
        BUSY_LO: if (!busy_s) begin
          tmr_load       = 1'b1;
          tmr_load_value = TIMER_W'(RD_LOW_TICKS - 1);
        end
        RD_LO: if (rd_last) begin
          tmr_load       = 1'b1;
          tmr_load_value = TIMER_W'(RD_HIGH_TICKS - 1);
        end
        RD_HI: if (tmr_expired) begin
          tmr_load       = 1'b1;
          tmr_load_value = TIMER_W'(RD_LOW_TICKS - 1);
        end
        default: tmr_load = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= OFF;
      ready        <= 1'b0;
      adc_reset    <= 1'b0;
      adc_convst_n <= 1'b1;
      adc_cs_n     <= 1'b1;
      adc_rd_n     <= 1'b1;
      sample_valid <= 1'b0;
      sample_ch    <= '0;
      sample_data  <= '0;
      frame_done   <= 1'b0;
      timeout_err  <= 1'b0;
      ch_cnt       <= '0;
    end else begin
      sample_valid <= 1'b0;
      frame_done   <= 1'b0;
      if (!power) begin
        state        <= OFF;
        ready        <= 1'b0;
        adc_reset    <= 1'b0;
        adc_convst_n <= 1'b1;
        adc_cs_n     <= 1'b1;
        adc_rd_n     <= 1'b1;
        timeout_err  <= 1'b0;
      end else begin
        case (state)
          OFF: state <= PWR_WAIT;
          PWR_WAIT: if (tmr_expired) begin
            state     <= ADC_RST;
            adc_reset <= 1'b1;
          end
          ADC_RST: if (tmr_expired) begin
            state     <= IDLE;
            adc_reset <= 1'b0;
            ready     <= 1'b1;
          end
          IDLE: if (start) begin
            state        <= CONVST;
            ready        <= 1'b0;
            adc_convst_n <= 1'b0;
          end
          CONVST: if (tmr_expired) begin
            state        <= BUSY_HI;
            adc_convst_n <= 1'b1;
          end
          BUSY_HI, BUSY_LO: begin
            if (busy_s == (state == BUSY_HI)) begin
              if (state == BUSY_HI) begin
                state <= BUSY_LO;
              end else begin
                state    <= RD_LO;
                adc_cs_n <= 1'b0;
                adc_rd_n <= 1'b0;
                ch_cnt   <= '0;
              end
            end else if (tmr_expired) begin
              // ADC never answered: give up on this frame, keep the error sticky.
              state        <= IDLE;
              ready        <= 1'b1;
              timeout_err  <= 1'b1;
              adc_convst_n <= 1'b1;
              adc_cs_n     <= 1'b1;
              adc_rd_n     <= 1'b1;
            end
          end
          RD_LO: if (rd_last) begin
            adc_rd_n     <= 1'b1;
            sample_valid <= 1'b1;
            sample_ch    <= ch_cnt;
            sample_data  <= adc_db;
            if (ch_cnt == LAST_CH) begin
              state      <= IDLE;
              ready      <= 1'b1;
              adc_cs_n   <= 1'b1;
              frame_done <= 1'b1;
            end else begin
              state <= RD_HI;
            end
          end
          RD_HI: if (tmr_expired) begin
            state    <= RD_LO;
            adc_rd_n <= 1'b0;
            ch_cnt   <= ch_cnt + 1'b1;
          end
          default: state <= OFF;
        endcase
      end
    end
  end

endmodule

// File: doc/ad7606_conv_ctrl.md
# ad7606_conv_ctrl

Sequencer for one AD7606 8-channel simultaneous-sampling ADC on the parallel interface. It does the following in order:
- waits out the power-on settling time after `power` rises;
- pulses the ADC RESET pin;
- on each `start` request, issues CONVST and waits for the BUSY pulse;
- reads the 8 channels with CS/RD strobes and streams them out as (channel, data) beats.

It sits between the acquisition scheduler and the ADC pins and owns all ADC control timing.

## Interface
Parameters:
- `CLK_FREQUENCY`, 30_000_000: clk rate in Hz, used only to derive the tick defaults below.
- `POWER_ON_TICKS`, 30 * (CLK_FREQUENCY/1_000): settling wait after `power` rises (30 ms). Benches set it to 10.
- `RESET_TICKS`, 2: ADC RESET high width (≥50 ns).
- `CONVST_LOW_TICKS`, 2: CONVST low width (≥25 ns).
- `RD_LOW_TICKS`, 2: RD low width. Data is captured on the last low cycle.
- `RD_HIGH_TICKS`, 1: RD high gap between channels.
- `BUSY_TIMEOUT_TICKS`, 300: maximum wait for each BUSY edge (10 µs at 30 MHz).
- `NUM_CH`, 8: channels read per frame.
- `DATA_W`, 16: ADC word width.

Ports:
- `clk` in 1: single clock for all logic.
- `rst` in 1: asynchronous, active-high reset.
- `power` in 1: level. 1 = ADC powered/enabled; 0 = shut down.
- `start` in 1: request one conversion frame. Accepted only when `ready`=1.
- `ready` out 1: high in IDLE only.
- `adc_reset` out 1: ADC RESET pin, active high.
- `adc_convst_n` out 1: CONVSTA/B tied together; rising edge starts conversion.
- `adc_busy` in 1: ADC BUSY, asynchronous. Passed through a 2-flop synchronizer internally.
- `adc_cs_n` out 1: chip select.
- `adc_rd_n` out 1: read strobe.
- `adc_db` in DATA_W: parallel data bus.
- `sample_valid` out 1: one-cycle pulse per channel word.
- `sample_ch` out $clog2(NUM_CH): channel index, 0..NUM_CH-1.
- `sample_data` out DATA_W: captured word, two's complement, passed through unmodified.
- `frame_done` out 1: one-cycle pulse, concurrent with the last `sample_valid`.
- `timeout_err` out 1: sticky. Set on a BUSY timeout; cleared by `rst` or by `power` going 0.

## Operation
- **States:** OFF, PWR_WAIT, ADC_RST, IDLE, CONVST, BUSY_HI, BUSY_LO, RD_LO, RD_HI.
- **OFF:** if `power`=1, go to PWR_WAIT and load the timer with POWER_ON_TICKS.
- **PWR_WAIT:** on timer expiry, go to ADC_RST. `adc_reset`=1 for RESET_TICKS cycles, then go to IDLE.
- **IDLE:** `ready`=1. `start`=1 → CONVST with `adc_convst_n`=0 for CONVST_LOW_TICKS cycles, then `adc_convst_n` returns to 1 → BUSY_HI.
- **BUSY_HI:** wait for synchronized BUSY=1, then go to BUSY_LO. Wait for BUSY=0, then go to RD_LO with channel counter 0.
  - Each wait has its own BUSY_TIMEOUT_TICKS budget.
  - On expiry: set `timeout_err`, deassert all strobes, go to IDLE. No samples are emitted.
- **RD_LO:** `adc_cs_n`=0, `adc_rd_n`=0 for RD_LOW_TICKS cycles.
  - On the last low cycle, register `adc_db` into `sample_data` and the counter into `sample_ch`.
  - Pulse `sample_valid` on the following cycle.
- **RD_HI:** `adc_rd_n`=1 for RD_HIGH_TICKS cycles with `adc_cs_n` held 0, then go to the next RD_LO.
  - After channel NUM_CH-1, `adc_cs_n`=1 and the FSM goes to IDLE.
  - `frame_done` pulses with the final `sample_valid`.
- **`power`=0 in any state:** go to OFF on the next cycle.
  - All strobes go idle (`adc_convst_n`/`adc_cs_n`/`adc_rd_n`=1, `adc_reset`=0).
  - A partial frame is abandoned and `frame_done` does not pulse.
  - Re-asserting `power` repeats the full PWR_WAIT + ADC_RST sequence.
- **`start` outside IDLE:** ignored, not queued. A `start` held high runs back-to-back frames.
- The channel counter has width $clog2(NUM_CH) and never wraps mid-frame. The terminal check is the counter equal to NUM_CH-1.

## Timing
- **Reset values:** state=OFF, `ready`=0, `adc_reset`=0, `adc_convst_n`=1, `adc_cs_n`=1, `adc_rd_n`=1, `sample_valid`=0, `sample_ch`=0, `sample_data`=0, `frame_done`=0, `timeout_err`=0.
- All outputs are registered.
- **Start latency:** `start` sampled high at edge T → `ready`=0 and `adc_convst_n`=0 from T+1 for exactly CONVST_LOW_TICKS cycles.
- **BUSY latency:** BUSY edges are seen 2 cycles late through the synchronizer. The timeout counts synchronized cycles.
- **Per-channel period:** RD_LOW_TICKS + RD_HIGH_TICKS cycles. Readout with defaults is 8×3 cycles minus the trailing RD_HI gap.
- **`rst` mid-frame:** outputs go to reset values immediately (asynchronous). Operation restarts from OFF.

## Structure
- Package `ad7606_pkg`: state enum `ad7606_state_t` and the default tick constants.
- Sub-module `ad7606_tick_timer`: a loadable down-counter with `load`, `value`, and `expired` outputs. It is shared by every timed state.
- The 2-flop BUSY synchronizer stays inline.

## Test plan
- **Power-up:** POWER_ON_TICKS=10, raise `power` at cycle 0 → `adc_reset` high cycles 11–12, `ready`=1 at cycle 13.
- **Full frame:** ADC model asserts BUSY 3 cycles after CONVST rises, holds it 20 cycles, and drives word 0x1000+ch → 8 `sample_valid` beats with ch 0..7 and data 0x1000..0x1007. `frame_done` coincides with ch 7. `adc_rd_n` low exactly 2 cycles per beat.
- **BUSY never rises:** → `timeout_err`=1 after 300 synchronized cycles, no `sample_valid`, `ready`=1 again. The next frame with a good model succeeds with `timeout_err` still 1.
- **`power` drops during channel 4 read:** → all strobes idle next cycle, no `frame_done`. Re-power repeats the full PWR_WAIT + ADC_RST sequence.
- **`start` during readout:** → ignored. A single `start` pulse yields exactly one frame. `start` held high yields back-to-back frames with one IDLE cycle between them.
- **Async `rst` while `adc_rd_n`=0:** → `adc_rd_n`=1 and `adc_cs_n`=1 before the next clk edge, all outputs at reset values.
